// File: rtl/cgol_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cgol_pkg
//  Purpose  : Shared board type, grid size and seed patterns for the cgol
//             Game of Life engine.
//  Revision : 1.0  initial release
// ============================================================================
package cgol_pkg;

    localparam int GRID = 8;

    // board[r][c]: row r, column c (bit c of the row byte)
    typedef logic [GRID-1:0][GRID-1:0] board_t;

    localparam board_t SEED_GLIDER = {
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'b0000_0111, 8'b0000_0100, 8'b0000_0010
    };

    localparam board_t SEED_BLINKER = {
        8'h00, 8'h00, 8'h00, 8'h00,
        8'b0001_1100,
        8'h00, 8'h00, 8'h00
    };

    localparam board_t SEED_BLOCK = {
        8'h00, 8'h00, 8'h00,
        8'b0001_1000, 8'b0001_1000,
        8'h00, 8'h00, 8'h00
    };

    localparam board_t SEED_CLEAR = '0;

    // Lowest set request bit selects the pattern.
    function automatic board_t seed_select(input logic [3:0] req);
        board_t seed;
        seed = SEED_CLEAR;
        if (req[0])      seed = SEED_GLIDER;
        else if (req[1]) seed = SEED_BLINKER;
        else if (req[2]) seed = SEED_BLOCK;
        else             seed = SEED_CLEAR;
        return seed;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cgol_next_gen.sv
`default_nettype none
// ============================================================================
//  Module   : cgol_next_gen
//  Purpose  : Combinational B3/S23 generation step on a toroidal 8x8 board.
//  Revision : 1.0  initial release
// ============================================================================
module cgol_next_gen
    import cgol_pkg::*;
(
    input  board_t i_board,
    output board_t o_board
);

    for (genvar r = 0; r < GRID; r++) begin : g_row
        localparam int c_row_up = (r + GRID - 1) % GRID;
        localparam int c_row_dn = (r + 1) % GRID;

        for (genvar c = 0; c < GRID; c++) begin : g_col
            localparam int c_col_lo = (c + GRID - 1) % GRID;
            localparam int c_col_hi = (c + 1) % GRID;

            logic [3:0] w_count;

            assign w_count = 4'(i_board[c_row_up][c_col_lo])
                           + 4'(i_board[c_row_up][c])
                           + 4'(i_board[c_row_up][c_col_hi])
                           + 4'(i_board[r][c_col_lo])
                           + 4'(i_board[r][c_col_hi])
                           + 4'(i_board[c_row_dn][c_col_lo])
                           + 4'(i_board[c_row_dn][c])
                           + 4'(i_board[c_row_dn][c_col_hi]);

            // Birth on exactly 3; survival on 2 or 3.
            assign o_board[r][c] = (w_count == 4'd3)
                                 || (i_board[r][c] && (w_count == 4'd2));
        end
    end

endmodule
`default_nettype wire

// File: rtl/cgol.sv
`default_nettype none
// ============================================================================
//  Module   : cgol
//  Purpose  : 8x8 toroidal Game of Life engine with row-scanned LED output.
//  Revision : 1.0  initial release
// ============================================================================
module cgol
    import cgol_pkg::*;
#(
    parameter int SCAN_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] load,
    output logic [7:0] row,
    output logic [7:0] col
);

    localparam logic [7:0] c_last_frame = 8'(SCAN_FRAMES - 1);

    board_t     r_board;
    logic [2:0] r_row_idx;
    logic [7:0] r_frame_cnt;

    board_t     w_next_board;
    board_t     w_seed;
    logic       w_load_req;
    logic       w_last_row;
    logic       w_last_frame;

    cgol_next_gen u_next_gen (
        .i_board (r_board),
        .o_board (w_next_board)
    );

    assign w_seed       = seed_select(load);
    assign w_load_req   = |load;
    assign w_last_row   = (r_row_idx == 3'd7);
    assign w_last_frame = (r_frame_cnt == c_last_frame);

    // A load restarts the scan and wins over a same-cycle generation step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_board     <= SEED_GLIDER;
            r_row_idx   <= 3'd0;
            r_frame_cnt <= 8'd0;
        end else if (w_load_req) begin
            r_board     <= w_seed;
            r_row_idx   <= 3'd0;
            r_frame_cnt <= 8'd0;
        end else begin
            r_row_idx <= r_row_idx + 3'd1;
            if (w_last_row) begin
                if (w_last_frame) begin
                    r_board     <= w_next_board;
                    r_frame_cnt <= 8'd0;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
            end
        end
    end

    assign row = 8'h01 << r_row_idx;
    assign col = r_board[r_row_idx];

endmodule
`default_nettype wire

// File: tb/tb_cgol.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cgol
//  Purpose  : Directed self-checking bench for the cgol engine (SCAN_FRAMES=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_cgol;

    typedef logic [7:0] frame_t [8];

    localparam frame_t F_GLIDER  = '{8'h02, 8'h04, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam frame_t F_GEN1    = '{8'h00, 8'h05, 8'h06, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam frame_t F_GEN4    = '{8'h00, 8'h04, 8'h08, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam frame_t F_BLINK_H = '{8'h00, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam frame_t F_BLINK_V = '{8'h00, 8'h00, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00};
    localparam frame_t F_BLOCK   = '{8'h00, 8'h00, 8'h00, 8'h18, 8'h18, 8'h00, 8'h00, 8'h00};

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] load = 4'b0000;
    logic [7:0] row;
    logic [7:0] col;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cgol #(.SCAN_FRAMES(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .row     (row),
        .col     (col)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        load    = 4'b1111;
        repeat (3) begin
            step();
            n_cmp++;
            if ({row, col} !== {8'h01, 8'h02}) begin
                n_err++;
                $display("FAIL reset_hold: row/col got %h/%h expected 01/02", row, col);
            end
        end
        load = 4'b0000;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Starts sampling at cycle 0 (right after release or load).
    task automatic test_glider_gen1();
        logic [7:0] exp_row;
        logic [7:0] exp_col;
        for (int k = 0; k < 40; k++) begin
            exp_row = 8'h01 << (k % 8);
            exp_col = (k < 32) ? F_GLIDER[k % 8] : F_GEN1[k % 8];
            n_cmp++;
            if ({row, col} !== {exp_row, exp_col}) begin
                n_err++;
                $display("FAIL glider_gen1 cyc %0d: row/col got %h/%h expected %h/%h",
                         k, row, col, exp_row, exp_col);
            end
            step();
        end
    endtask

    task automatic test_blinker();
        logic [7:0] exp_row;
        logic [7:0] exp_col;
        @(negedge clk);
        load = 4'b0010;
        step();
        load = 4'b0000;
        for (int k = 0; k < 96; k++) begin
            exp_row = 8'h01 << (k % 8);
            exp_col = ((k / 32) == 1) ? F_BLINK_V[k % 8] : F_BLINK_H[k % 8];
            n_cmp++;
            if ({row, col} !== {exp_row, exp_col}) begin
                n_err++;
                $display("FAIL blinker cyc %0d: row/col got %h/%h expected %h/%h",
                         k, row, col, exp_row, exp_col);
            end
            step();
        end
    endtask

    task automatic test_block();
        logic [7:0] exp_row;
        @(negedge clk);
        load = 4'b0100;
        step();
        load = 4'b0000;
        for (int k = 0; k < 5 * 32 + 8; k++) begin
            exp_row = 8'h01 << (k % 8);
            n_cmp++;
            if ({row, col} !== {exp_row, F_BLOCK[k % 8]}) begin
                n_err++;
                $display("FAIL block cyc %0d: row/col got %h/%h expected %h/%h",
                         k, row, col, exp_row, F_BLOCK[k % 8]);
            end
            step();
        end
    endtask

    task automatic test_priority_clear();
        logic [7:0] exp_row;
        @(negedge clk);
        load = 4'b1111;
        repeat (3) begin
            step();
            n_cmp++;
            if ({row, col} !== {8'h01, 8'h02}) begin
                n_err++;
                $display("FAIL load_priority: row/col got %h/%h expected 01/02", row, col);
            end
        end
        load = 4'b1000;
        step();
        load = 4'b0000;
        for (int k = 0; k < 96; k++) begin
            exp_row = 8'h01 << (k % 8);
            n_cmp++;
            if ({row, col} !== {exp_row, 8'h00}) begin
                n_err++;
                $display("FAIL clear cyc %0d: row/col got %h/%h expected %h/00",
                         k, row, col, exp_row);
            end
            step();
        end
    endtask

    task automatic test_glider_wrap();
        reset_n = 1'b0;
        #2;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 1032; k++) begin
            if (k >= 128 && k < 136) begin
                n_cmp++;
                if (col !== F_GEN4[k % 8]) begin
                    n_err++;
                    $display("FAIL glider_gen4 cyc %0d: col got %h expected %h",
                             k, col, F_GEN4[k % 8]);
                end
            end
            if (k >= 1024) begin
                n_cmp++;
                if (col !== F_GLIDER[k % 8]) begin
                    n_err++;
                    $display("FAIL glider_gen32 cyc %0d: col got %h expected %h",
                             k, col, F_GLIDER[k % 8]);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        reset_n = 1'b0;
        #2;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (101) step();
        n_cmp++;
        if (row !== 8'h20) begin
            n_err++;
            $display("FAIL mid_position: row got %h expected 20", row);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({row, col} !== {8'h01, 8'h02}) begin
            n_err++;
            $display("FAIL async_reset: row/col got %h/%h expected 01/02", row, col);
        end
        @(negedge clk);
        reset_n = 1'b1;
        test_glider_gen1();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_glider_gen1();
        test_blinker();
        test_block();
        test_priority_clear();
        test_glider_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
